// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + RAW/WAW scoreboard in front of the 32x32 register file.
// Define WB_FIXED_PRIO_EN for fixed priority (req1 wins); default is round-robin.
module regfile_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  output logic            issue_stall,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data
);

  logic            gnt0, gnt1, acc;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [31:0]     busy_q, busy_d;
  logic            issue_take;

`ifdef WB_FIXED_PRIO_EN
  // Multi-cycle results always win so they are never starved.
  assign gnt1 = req1_valid;
  assign gnt0 = req0_valid & ~req1_valid;
`else
  // lg_q = last granted requester; on contention the other one wins.
  logic lg_q, lg_d;
  assign gnt0 = req0_valid & (~req1_valid | lg_q);
  assign gnt1 = req1_valid & (~req0_valid | ~lg_q);
  assign lg_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : lg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lg_q <= 1'b1;
    else        lg_q <= lg_d;
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc        = gnt0 | gnt1;
  assign acc_rd     = gnt1 ? req1_rd   : req0_rd;
  assign acc_data   = gnt1 ? req1_data : req0_data;

  assign regwrite_d = acc & (acc_rd != 5'd0);
  assign rd_d       = acc ? acc_rd   : rd_q;
  assign rd_data_d  = acc ? acc_data : rd_data_q;

  assign issue_stall = issue_valid &
                       (((issue_rs1 != 5'd0) & busy_q[issue_rs1]) |
                        ((issue_rs2 != 5'd0) & busy_q[issue_rs2]) |
                        ((issue_rd  != 5'd0) & busy_q[issue_rd]));
  assign issue_take  = issue_valid & ~issue_stall & (issue_rd != 5'd0);

  // Clear first so a same-edge set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) busy_d[rd_q] = 1'b0;
    if (issue_take) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      rd_data_q  <= '0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign rd       = rd_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, scoreboard, arbitration, same-edge and mid-op reset.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic [4:0]      req0_rd, req1_rd;
  logic [XLEN-1:0] req0_data, req1_data;
  logic            req0_ready, req1_ready;
  logic            issue_valid;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            issue_stall;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .RegWrite(RegWrite), .rd(rd), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] d);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = d;
  endtask

  logic exp0, exp1;

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    issue(0, 0, 0, 0);
    #12;
    check("rst_regwrite", RegWrite, 0);
    check("rst_rd", rd, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_stall", issue_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Issue rd=5, then a reader of x5 must stall.
    issue(1, 0, 0, 5);
    #1 check("issue_rd5_stall", issue_stall, 0);
    tick();
    issue(1, 5, 0, 0);
    #1 check("raw_rs1_5_stall", issue_stall, 1);
    issue(0, 0, 0, 0);

    // Contention for 4 cycles.
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
`ifdef WB_FIXED_PRIO_EN
      exp0 = 1'b0; exp1 = 1'b1;
`else
      exp0 = (k % 2 == 0); exp1 = (k % 2 == 1);
`endif
      #1;
      check($sformatf("arb_ready0_c%0d", k), req0_ready, exp0);
      check($sformatf("arb_ready1_c%0d", k), req1_ready, exp1);
      tick();
      check($sformatf("arb_rd_c%0d", k), rd, exp1 ? 32'd2 : 32'd1);
    end
    req0_valid = 0; req1_valid = 0;

    // Lone req0 write-back to x5; stall clears two cycles after acceptance.
    issue(1, 5, 0, 0);
    req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("wb5_ready0", req0_ready, 1);
    check("wb5_ready1", req1_ready, 0);
    check("wb5_stall_N", issue_stall, 1);
    tick();
    req0_valid = 0;
    #1;
    check("wb5_regwrite", RegWrite, 1);
    check("wb5_rd", rd, 5);
    check("wb5_rd_data", rd_data, 32'hDEADBEEF);
    check("wb5_stall_N1", issue_stall, 1);
    tick();
    check("wb5_stall_N2", issue_stall, 0);
    check("wb5_regwrite_N2", RegWrite, 0);
    check("wb5_rd_hold", rd_data, 32'hDEADBEEF);
    issue(0, 0, 0, 0);

    // rd=0 write-back consumes the slot but never writes.
    req1_valid = 1; req1_rd = 5'd0; req1_data = 32'h1234;
    #1 check("x0_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("x0_regwrite", RegWrite, 0);
    check("x0_rd", rd, 0);
    check("x0_rd_data", rd_data, 32'h1234);

    // Same-edge clear and set of x7: set wins.
    req0_valid = 1; req0_rd = 5'd7; req0_data = 32'h77;
    tick();
    req0_valid = 0;
    check("same_regwrite", RegWrite, 1);
    check("same_rd", rd, 7);
    issue(1, 0, 0, 7);
    #1 check("same_issue7_stall", issue_stall, 0);
    tick();
    issue(1, 0, 7, 0);
    #1 check("same_rs2_7_stall", issue_stall, 1);

    // Mid-operation reset with busy={3,7,9} and a write in the output stage.
    issue(1, 0, 0, 3);
    tick();
    issue(1, 0, 0, 9);
    tick();
    issue(1, 3, 9, 0);
    #1 check("pre_rst_stall", issue_stall, 1);
    issue(0, 0, 0, 0);
    req0_valid = 1; req0_rd = 5'd4; req0_data = 32'hAA;
    tick();
    req0_valid = 0;
    check("pre_rst_regwrite", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", RegWrite, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_rd_data", rd_data, 0);
    issue(1, 3, 9, 0);
    #1 check("mid_rst_stall_3_9", issue_stall, 0);
    issue(1, 0, 7, 0);
    #1 check("mid_rst_stall_7", issue_stall, 0);
    issue(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h1;
    req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h2;
    #1;
`ifdef WB_FIXED_PRIO_EN
    check("post_rst_ready0", req0_ready, 0);
    check("post_rst_ready1", req1_ready, 1);
`else
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
`endif
    tick();
    req0_valid = 0; req1_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
